firebird7_in_gate1_tessent_data_mux_ctrl: RTL and testbench
===========================================================

FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CTRL -- requirements
Module: firebird7_in_gate1_tessent_data_mux_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, which is the width of the controlled data mux.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1, legal range 1..15, which is the dwell in each handover state.
REQ-003 The block SHALL have port ijtag_tck, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port ijtag_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ijtag_sel, input, 1 bit: segment select.
REQ-006 The block SHALL have ports ijtag_ce, ijtag_se and ijtag_ue, inputs, 1 bit each: capture, shift and update enables.
REQ-007 The block SHALL have port ijtag_si, input, 1 bit: scan in.
REQ-008 The block SHALL have port ijtag_so, output, 1 bit: scan out, equal to shift register bit 0.
REQ-009 The block SHALL have port functional_data_in, input, WIDTH bits: the observed functional value.
REQ-010 The block SHALL have port mux_select, output, 1 bit: drives the data mux ijtag_select.
REQ-011 The block SHALL have port mux_data, output, WIDTH bits: drives the data mux ijtag_data_in.
REQ-012 The block SHALL have port handover_busy, output, 1 bit: high while a handover is in progress.

Function
REQ-013 The block SHALL contain a shift register sr[WIDTH:0]; sr[WIDTH] is the select request and sr[WIDTH-1:0] is the data.
REQ-014 Shift: when ijtag_sel & ijtag_se, sr SHALL become {ijtag_si, sr[WIDTH:1]} each cycle.
REQ-015 Capture: when ijtag_sel & ijtag_ce & !ijtag_se, sr SHALL load the capture value defined under Configuration.
REQ-016 Update: when ijtag_sel & ijtag_ue & !ijtag_se, the update register {upd_sel, upd_data} SHALL load sr.
REQ-017 Under any other enable combination, sr and the update register SHALL hold their values.
REQ-018 The handover FSM SHALL have four states: FUNC, LOAD, OVR and REL.
REQ-019 FUNC: mux_select=0 and mux_data=0; if upd_sel=1, the FSM SHALL go to LOAD.
REQ-020 LOAD: mux_data=upd_data and mux_select=0; after SETTLE_CYCLES cycles the FSM SHALL go to OVR.
REQ-021 OVR: mux_select=1 and mux_data SHALL track upd_data with 1-cycle latency; if upd_sel=0, the FSM SHALL go to REL.
REQ-022 REL: mux_select=0 and mux_data SHALL hold its last value; after SETTLE_CYCLES cycles mux_data SHALL become 0 and the FSM SHALL go to FUNC.
REQ-023 mux_select and mux_data SHALL never change in the same cycle (make-before-break).
REQ-024 handover_busy SHALL be 1 exactly in LOAD and REL.
REQ-025 An update during LOAD or REL SHALL NOT abort the handover; the FSM SHALL re-evaluate upd_sel on reaching OVR or FUNC.
REQ-026 The dwell counter SHALL be 4 bits wide, reload on state entry, and saturate rather than wrap.
REQ-027 Simultaneous update and FSM transition: the FSM SHALL act on the pre-update upd_sel; the new value SHALL take effect the next cycle.

Reset
REQ-028 On ijtag_reset=0, sr, upd_sel, upd_data, mux_data, mux_select, handover_busy and the dwell counter SHALL all go to 0 and the FSM to FUNC, immediately and asynchronously.
REQ-029 Reset asserted mid-handover or mid-shift SHALL return the block to FUNC with no intermediate mux_select pulse.
REQ-030 Deassertion SHALL take effect on the first ijtag_tck rising edge after release.

Configuration
REQ-031 With FIREBIRD7_DMUX_CTRL_STATUS_EN defined, the capture value SHALL be {mux_select, functional_data_in}, so the live mux state is observable.
REQ-032 Without FIREBIRD7_DMUX_CTRL_STATUS_EN, the capture value SHALL be {upd_sel, upd_data} (readback), and functional_data_in SHALL remain a port but be unused.

Structure
REQ-033 A shared package firebird7_in_gate1_dmux_ctrl_pkg SHALL hold the FSM state enum (FUNC, LOAD, OVR, REL) and the dwell-counter width constant.
REQ-034 The design SHALL contain one sub-module, firebird7_in_gate1_dmux_ctrl_tdr, implementing shift, capture and update; the FSM SHALL live in the top module.

Verification
REQ-035 Bench scenario: shift 4'b1101, then update (SETTLE_CYCLES=1) -> mux_data=3'b101 one cycle before mux_select=1, with handover_busy=1 for 1 cycle.
REQ-036 Bench scenario: in OVR, update 4'b1010 -> mux_data=3'b010 the next cycle, mux_select stays 1, handover_busy stays 0.
REQ-037 Bench scenario: update 4'b0xxx from OVR with SETTLE_CYCLES=3 -> mux_select=0, mux_data held for 3 cycles, then 0, then FSM=FUNC.
REQ-038 Bench scenario: with the macro defined, functional_data_in=3'b110, mux_select=0, then capture and shift 4 bits -> ijtag_so sequence 0,1,1,0 (LSB first).
REQ-039 Bench scenario: assert ijtag_reset in LOAD -> all outputs 0 with no clock edge; after release, FSM=FUNC.
REQ-040 Bench scenario: update 4'b1001 then 4'b0001 during LOAD -> OVR is reached, then REL the next cycle; no cycle shows mux_select and mux_data changing together.

Source files
------------

// File: rtl/firebird7_in_gate1_dmux_ctrl_pkg.sv
// firebird7 data-mux controller shared types and helpers.
// Handover state encoding plus the 4-bit dwell counter arithmetic.
package firebird7_in_gate1_dmux_ctrl_pkg;

    localparam int DWELL_W = 4;

    typedef logic [DWELL_W-1:0] dwell_t;

    localparam dwell_t DWELL_MAX  = '1;
    localparam dwell_t DWELL_LAST = dwell_t'(1);

    typedef enum logic [1:0] {
        FUNC = 2'd0,
        LOAD = 2'd1,
        OVR  = 2'd2,
        REL  = 2'd3
    } hand_state_e;

    // Out-of-range settle values are clamped so the dwell is never zero.
    function automatic dwell_t dwell_load(input int cycles);
        if (cycles < 1)
            return DWELL_LAST;
        if (cycles > int'(DWELL_MAX))
            return DWELL_MAX;
        return dwell_t'(cycles);
    endfunction

    function automatic dwell_t dwell_dec(input dwell_t d);
        return (d == '0) ? d : d - DWELL_LAST;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_if.sv
// IJTAG segment bus between the scan network and the data-mux controller.
// master drives the enables and scan-in, slave returns scan-out.
interface firebird7_in_gate1_tessent_data_mux_ctrl_if;

    logic ijtag_sel;
    logic ijtag_ce;
    logic ijtag_se;
    logic ijtag_ue;
    logic ijtag_si;
    logic ijtag_so;

    modport master (
        output ijtag_sel,
        output ijtag_ce,
        output ijtag_se,
        output ijtag_ue,
        output ijtag_si,
        input  ijtag_so
    );

    modport slave (
        input  ijtag_sel,
        input  ijtag_ce,
        input  ijtag_se,
        input  ijtag_ue,
        input  ijtag_si,
        output ijtag_so
    );

endinterface

// File: rtl/firebird7_in_gate1_dmux_ctrl_tdr.sv
// Test data register: shift/capture path sr[WIDTH:0] and update register.
// sr[WIDTH] carries the select request, sr[WIDTH-1:0] the mux data.
module firebird7_in_gate1_dmux_ctrl_tdr
    import firebird7_in_gate1_dmux_ctrl_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                                       ijtag_tck,
    input  logic                                       ijtag_reset,
    firebird7_in_gate1_tessent_data_mux_ctrl_if.slave  ijtag,
    input  logic [WIDTH:0]                             cap_val,
    output logic                                       upd_sel,
    output logic [WIDTH-1:0]                           upd_data
);

    logic [WIDTH:0] sr;

    logic do_shift;
    logic do_cap;
    logic do_upd;

    assign do_shift = ijtag.ijtag_sel & ijtag.ijtag_se;
    assign do_cap   = ijtag.ijtag_sel & ijtag.ijtag_ce & ~ijtag.ijtag_se;
    assign do_upd   = ijtag.ijtag_sel & ijtag.ijtag_ue & ~ijtag.ijtag_se;

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr <= '0;
        end else if (do_shift) begin
            sr <= {ijtag.ijtag_si, sr[WIDTH:1]};
        end else if (do_cap) begin
            sr <= cap_val;
        end
    end

    // Update samples sr before any same-edge capture lands.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            upd_sel  <= 1'b0;
            upd_data <= '0;
        end else if (do_upd) begin
            upd_sel  <= sr[WIDTH];
            upd_data <= sr[WIDTH-1:0];
        end
    end

    assign ijtag.ijtag_so = sr[0];

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Make-before-break handover controller for an IJTAG-driven data mux.
// Define FIREBIRD7_DMUX_CTRL_STATUS_EN to capture live {mux_select, data_in}.
module firebird7_in_gate1_tessent_data_mux_ctrl
    import firebird7_in_gate1_dmux_ctrl_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                                       ijtag_tck,
    input  logic                                       ijtag_reset,
    firebird7_in_gate1_tessent_data_mux_ctrl_if.slave  ijtag,
    input  logic [WIDTH-1:0]                           functional_data_in,
    output logic                                       mux_select,
    output logic [WIDTH-1:0]                           mux_data,
    output logic                                       handover_busy
);

    localparam dwell_t SETTLE = dwell_load(SETTLE_CYCLES);

    logic             upd_sel;
    logic [WIDTH-1:0] upd_data;
    logic [WIDTH:0]   cap_val;

`ifdef FIREBIRD7_DMUX_CTRL_STATUS_EN
    assign cap_val = {mux_select, functional_data_in};
`else
    logic unused_fdi;

    assign cap_val    = {upd_sel, upd_data};
    assign unused_fdi = ^functional_data_in;
`endif

    firebird7_in_gate1_dmux_ctrl_tdr #(
        .WIDTH (WIDTH)
    ) u_tdr (
        .ijtag_tck   (ijtag_tck),
        .ijtag_reset (ijtag_reset),
        .ijtag       (ijtag),
        .cap_val     (cap_val),
        .upd_sel     (upd_sel),
        .upd_data    (upd_data)
    );

    hand_state_e state;
    dwell_t      dwell;

    // Select and data never move on the same edge: data settles before
    // select rises, and is held until after select has fallen.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state         <= FUNC;
            dwell         <= '0;
            mux_select    <= 1'b0;
            mux_data      <= '0;
            handover_busy <= 1'b0;
        end else begin
            unique case (state)
                FUNC: begin
                    if (upd_sel) begin
                        state         <= LOAD;
                        dwell         <= SETTLE;
                        mux_data      <= upd_data;
                        handover_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (dwell <= DWELL_LAST) begin
                        state         <= OVR;
                        mux_select    <= 1'b1;
                        handover_busy <= 1'b0;
                    end else begin
                        dwell    <= dwell_dec(dwell);
                        mux_data <= upd_data;
                    end
                end
                OVR: begin
                    if (!upd_sel) begin
                        state         <= REL;
                        dwell         <= SETTLE;
                        mux_select    <= 1'b0;
                        handover_busy <= 1'b1;
                    end else begin
                        mux_data <= upd_data;
                    end
                end
                REL: begin
                    if (dwell <= DWELL_LAST) begin
                        state         <= FUNC;
                        mux_data      <= '0;
                        handover_busy <= 1'b0;
                    end else begin
                        dwell <= dwell_dec(dwell);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Bench: three controllers (settle 1, 3, 15) share one stimulus stream
// and are compared every cycle against a behavioural handover model.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

    logic       tck = 1'b0;
    logic       rst_l = 1'b0;
    logic [2:0] i_fdi = '0;
    logic       i_sel = 1'b0;
    logic       i_ce = 1'b0;
    logic       i_se = 1'b0;
    logic       i_ue = 1'b0;
    logic       i_si = 1'b0;

    logic [2:0]       msel;
    logic [2:0][2:0]  mdat;
    logic [2:0]       busy;
    logic [2:0]       so_v;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 tck = ~tck;

    firebird7_in_gate1_tessent_data_mux_ctrl_if if0 ();
    firebird7_in_gate1_tessent_data_mux_ctrl_if if1 ();
    firebird7_in_gate1_tessent_data_mux_ctrl_if if2 ();

    assign so_v = {if2.ijtag_so, if1.ijtag_so, if0.ijtag_so};

    firebird7_in_gate1_tessent_data_mux_ctrl #(
        .WIDTH(3), .SETTLE_CYCLES(1)
    ) u_dut0 (
        .ijtag_tck(tck), .ijtag_reset(rst_l), .ijtag(if0),
        .functional_data_in(i_fdi), .mux_select(msel[0]),
        .mux_data(mdat[0]), .handover_busy(busy[0])
    );

    firebird7_in_gate1_tessent_data_mux_ctrl #(
        .WIDTH(3), .SETTLE_CYCLES(3)
    ) u_dut1 (
        .ijtag_tck(tck), .ijtag_reset(rst_l), .ijtag(if1),
        .functional_data_in(i_fdi), .mux_select(msel[1]),
        .mux_data(mdat[1]), .handover_busy(busy[1])
    );

    firebird7_in_gate1_tessent_data_mux_ctrl #(
        .WIDTH(3), .SETTLE_CYCLES(15)
    ) u_dut2 (
        .ijtag_tck(tck), .ijtag_reset(rst_l), .ijtag(if2),
        .functional_data_in(i_fdi), .mux_select(msel[2]),
        .mux_data(mdat[2]), .handover_busy(busy[2])
    );

    // Reference model: phase 0 idle, 1 loading, 2 overriding, 3 releasing.
    int         settle [3] = '{1, 3, 15};
    logic [3:0] m_sr   [3];
    logic       m_usel [3];
    logic [2:0] m_udat [3];
    int         ph     [3];
    int         waited [3];
    logic       e_sel  [3];
    logic [2:0] e_dat  [3];
    logic       e_busy [3];
    logic       p_sel  [3];
    logic [2:0] p_dat  [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sr[k] = '0; m_usel[k] = 1'b0; m_udat[k] = '0;
            ph[k] = 0; waited[k] = 0;
            e_sel[k] = 1'b0; e_dat[k] = '0; e_busy[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [3:0] o_sr;
            logic       o_us;
            logic [2:0] o_ud;
            o_sr = m_sr[k]; o_us = m_usel[k]; o_ud = m_udat[k];
            if (i_sel && i_se)
                m_sr[k] = {i_si, o_sr[3:1]};
            else if (i_sel && i_ce)
`ifdef FIREBIRD7_DMUX_CTRL_STATUS_EN
                m_sr[k] = {e_sel[k], i_fdi};
`else
                m_sr[k] = {o_us, o_ud};
`endif
            if (i_sel && i_ue && !i_se) begin
                m_usel[k] = o_sr[3];
                m_udat[k] = o_sr[2:0];
            end
            case (ph[k])
                0: if (o_us) begin
                    ph[k] = 1; waited[k] = 0;
                    e_dat[k] = o_ud; e_busy[k] = 1'b1;
                end
                1: begin
                    waited[k]++;
                    if (waited[k] == settle[k]) begin
                        ph[k] = 2; e_sel[k] = 1'b1; e_busy[k] = 1'b0;
                    end else begin
                        e_dat[k] = o_ud;
                    end
                end
                2: if (!o_us) begin
                    ph[k] = 3; waited[k] = 0;
                    e_sel[k] = 1'b0; e_busy[k] = 1'b1;
                end else begin
                    e_dat[k] = o_ud;
                end
                default: begin
                    waited[k]++;
                    if (waited[k] == settle[k]) begin
                        ph[k] = 0; e_dat[k] = '0; e_busy[k] = 1'b0;
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap_prev();
        for (int k = 0; k < 3; k++) begin
            p_sel[k] = msel[k]; p_dat[k] = mdat[k];
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic both;
            both = (msel[k] !== p_sel[k]) && (mdat[k] !== p_dat[k]);
            chk($sformatf("sel%0d", k), 8'(msel[k]), 8'(e_sel[k]));
            chk($sformatf("data%0d", k), 8'(mdat[k]), 8'(e_dat[k]));
            chk($sformatf("busy%0d", k), 8'(busy[k]), 8'(e_busy[k]));
            chk($sformatf("so%0d", k), 8'(so_v[k]), 8'(m_sr[k][0]));
            chk($sformatf("mbb%0d", k), 8'(both), 8'd0);
        end
        snap_prev();
    endtask

    task automatic drive(input logic s, input logic ce, input logic se,
                         input logic ue, input logic si);
        i_sel = s; i_ce = ce; i_se = se; i_ue = ue; i_si = si;
        if0.ijtag_sel = s; if0.ijtag_ce = ce; if0.ijtag_se = se;
        if0.ijtag_ue = ue; if0.ijtag_si = si;
        if1.ijtag_sel = s; if1.ijtag_ce = ce; if1.ijtag_se = se;
        if1.ijtag_ue = ue; if1.ijtag_si = si;
        if2.ijtag_sel = s; if2.ijtag_ce = ce; if2.ijtag_se = se;
        if2.ijtag_ue = ue; if2.ijtag_si = si;
    endtask

    task automatic tick();
        @(posedge tck);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic shift_bits(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 0, v[i]);
            tick();
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic update();
        drive(1, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_sel%0d", k), 8'(msel[k]), 8'd0);
            chk($sformatf("rst_data%0d", k), 8'(mdat[k]), 8'd0);
            chk($sformatf("rst_busy%0d", k), 8'(busy[k]), 8'd0);
            chk($sformatf("rst_so%0d", k), 8'(so_v[k]), 8'd0);
        end
        snap_prev();
        #2 rst_l = 1'b1;
        idle(2);

`ifdef FIREBIRD7_DMUX_CTRL_STATUS_EN
        begin
            logic [3:0] seq;
            seq = 4'b0110;
            i_fdi = 3'b110;
            drive(1, 1, 0, 0, 0);
            tick();
            chk("cap_so", 8'(so_v[0]), 8'(seq[0]));
            for (int i = 1; i < 4; i++) begin
                drive(1, 0, 1, 0, 0);
                tick();
                chk($sformatf("cap_so_%0d", i), 8'(so_v[0]), 8'(seq[i]));
            end
            idle(1);
        end
`endif

        // Enter override with data 101 on the settle-1 controller.
        shift_bits(4'b1101);
        update();
        tick();
        chk("load_data", 8'(mdat[0]), 8'h5);
        chk("load_sel", 8'(msel[0]), 8'h0);
        chk("load_busy", 8'(busy[0]), 8'h1);
        tick();
        chk("ovr_sel", 8'(msel[0]), 8'h1);
        chk("ovr_busy", 8'(busy[0]), 8'h0);

        shift_bits(4'b1010);
        update();
        tick();
        chk("ovr_track", 8'(mdat[0]), 8'h2);
        chk("ovr_hold_sel", 8'(msel[0]), 8'h1);
        chk("ovr_nobusy", 8'(busy[0]), 8'h0);

        // Release on the settle-3 controller.
        idle(20);
        shift_bits(4'b0000);
        update();
        tick();
        chk("rel_sel", 8'(msel[1]), 8'h0);
        chk("rel_busy", 8'(busy[1]), 8'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("rel_hold%0d", i), 8'(mdat[1]), 8'h2);
        end
        tick();
        chk("rel_zero", 8'(mdat[1]), 8'h0);
        chk("rel_done", 8'(busy[1]), 8'h0);

        // Update during LOAD does not abort the handover.
        idle(20);
        shift_bits(4'b1001);
        update();
        shift_bits(4'b0001);
        update();
        n = 0;
        while (msel[2] !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("late_ovr", 8'(msel[2]), 8'h1);
        tick();
        chk("late_rel_sel", 8'(msel[2]), 8'h0);
        chk("late_rel_busy", 8'(busy[2]), 8'h1);

        // Asynchronous reset while loading.
        idle(20);
        shift_bits(4'b1011);
        update();
        tick();
        chk("pre_rst_data", 8'(mdat[0]), 8'h3);
        #2 rst_l = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("arst_sel%0d", k), 8'(msel[k]), 8'd0);
            chk($sformatf("arst_data%0d", k), 8'(mdat[k]), 8'd0);
            chk($sformatf("arst_busy%0d", k), 8'(busy[k]), 8'd0);
            chk($sformatf("arst_so%0d", k), 8'(so_v[k]), 8'd0);
        end
        snap_prev();
        #3 rst_l = 1'b1;
        idle(3);

        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)));
            i_fdi = 3'($urandom_range(0, 7));
            tick();
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
